// File: rtl/text_screen.sv
// text_screen: 80x30 character-cell terminal engine with a circular-row cell RAM
// and a pixel-aligned codepoint/attribute lookup for the console glyph renderer.
module text_screen #(
    parameter int         COLS         = 80,
    parameter int         ROWS         = 30,
    parameter int         H_TOTAL      = 800,
    parameter int         V_TOTAL      = 525,
    parameter logic [7:0] ATTR_DEFAULT = 8'h0F
) (
    input  logic       clk_pixel,
    input  logic       ext_reset,
    input  logic [9:0] cx,
    input  logic [9:0] cy,
    input  logic       char_valid,
    input  logic [7:0] char_data,
    input  logic [7:0] char_attr,
    output logic       char_ready,
    output logic [7:0] codepoint,
    output logic [7:0] attribute,
    output logic [6:0] cursor_col,
    output logic [4:0] cursor_row
);
    localparam int          CELLS = COLS * ROWS;
    localparam logic [15:0] BLANK = {ATTR_DEFAULT, 8'h20};

    typedef enum logic [1:0] {CLEAR_ALL, IDLE, CLEAR_ROW} state_t;

    state_t      state_q, state_d;
    logic [11:0] clr_q, clr_d;
    logic [4:0]  clr_row_q, clr_row_d;
    logic [4:0]  top_q, top_d;
    logic [6:0]  col_q, col_d;
    logic [4:0]  row_q, row_d;
    logic        vis_q;
    logic [15:0] rd_q;
    logic [15:0] mem_q [CELLS];

    logic [9:0]  nx, ny;
    logic        vis;
    logic [11:0] rd_addr, wr_addr;
    logic [15:0] wr_data;
    logic        we, lf;
    logic [4:0]  cur_phys;

    function automatic logic [4:0] wrap_row(input logic [4:0] a, input logic [4:0] b);
        logic [5:0] s;
        s = {1'b0, a} + {1'b0, b};
        s = (s >= 6'(ROWS)) ? s - 6'(ROWS) : s;
        return s[4:0];
    endfunction

    function automatic logic [11:0] cell_addr(input logic [4:0] r, input logic [6:0] c);
        return ({7'd0, r} << 6) + ({7'd0, r} << 4) + {5'd0, c};
    endfunction

    // Look one pixel ahead so the registered RAM read lines up with the current pixel.
    always_comb begin
        nx = (cx == 10'(H_TOTAL - 1)) ? 10'd0 : cx + 10'd1;
        ny = (cx != 10'(H_TOTAL - 1)) ? cy : (cy == 10'(V_TOTAL - 1)) ? 10'd0 : cy + 10'd1;
        vis = (nx < 10'(COLS * 8)) && (ny < 10'(ROWS * 16));
        rd_addr = vis ? cell_addr(wrap_row(ny[8:4], top_q), nx[9:3]) : 12'd0;
    end

    always_ff @(posedge clk_pixel) begin
        if (we)
            mem_q[wr_addr] <= wr_data;
        rd_q <= mem_q[rd_addr];
    end

    always_ff @(posedge clk_pixel or negedge ext_reset) begin
        if (!ext_reset) begin
            state_q   <= CLEAR_ALL;
            clr_q     <= 12'd0;
            clr_row_q <= 5'd0;
            top_q     <= 5'd0;
            col_q     <= 7'd0;
            row_q     <= 5'd0;
            vis_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_q     <= clr_d;
            clr_row_q <= clr_row_d;
            top_q     <= top_d;
            col_q     <= col_d;
            row_q     <= row_d;
            vis_q     <= vis;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_d     = clr_q;
        clr_row_d = clr_row_q;
        top_d     = top_q;
        col_d     = col_q;
        row_d     = row_q;
        lf        = 1'b0;
        we        = 1'b0;
        cur_phys  = wrap_row(row_q, top_q);
        wr_addr   = cell_addr(cur_phys, col_q);
        wr_data   = {char_attr, char_data};
        case (state_q)
            CLEAR_ALL: begin
                we      = 1'b1;
                wr_addr = clr_q;
                wr_data = BLANK;
                top_d   = 5'd0;
                col_d   = 7'd0;
                row_d   = 5'd0;
                clr_d   = (clr_q == 12'(CELLS - 1)) ? 12'd0 : clr_q + 12'd1;
                state_d = (clr_q == 12'(CELLS - 1)) ? IDLE : CLEAR_ALL;
            end
            CLEAR_ROW: begin
                we      = 1'b1;
                wr_addr = cell_addr(clr_row_q, clr_q[6:0]);
                wr_data = BLANK;
                clr_d   = (clr_q == 12'(COLS - 1)) ? 12'd0 : clr_q + 12'd1;
                state_d = (clr_q == 12'(COLS - 1)) ? IDLE : CLEAR_ROW;
            end
            default: begin
                if (char_valid) begin
                    case (char_data)
                        8'h0A: begin
                            col_d = 7'd0;
                            lf    = 1'b1;
                        end
                        8'h0D: col_d = 7'd0;
                        8'h08: begin
                            if (col_q != 7'd0) begin
                                col_d   = col_q - 7'd1;
                                we      = 1'b1;
                                wr_addr = cell_addr(cur_phys, col_q - 7'd1);
                                wr_data = BLANK;
                            end
                        end
                        8'h0C: begin
                            state_d = CLEAR_ALL;
                            clr_d   = 12'd0;
                        end
                        default: begin
                            we    = 1'b1;
                            lf    = (col_q == 7'(COLS - 1));
                            col_d = lf ? 7'd0 : col_q + 7'd1;
                        end
                    endcase
                    // Scrolling just advances the ring; the old top row becomes the new, cleared bottom.
                    if (lf && row_q != 5'(ROWS - 1))
                        row_d = row_q + 5'd1;
                    else if (lf) begin
                        top_d     = wrap_row(top_q, 5'd1);
                        clr_row_d = top_q;
                        clr_d     = 12'd0;
                        state_d   = CLEAR_ROW;
                    end
                end
            end
        endcase
    end

    assign char_ready = (state_q == IDLE);
    assign codepoint  = vis_q ? rd_q[7:0] : 8'd0;
    assign attribute  = vis_q ? rd_q[15:8] : 8'd0;
    assign cursor_col = col_q;
    assign cursor_row = row_q;
endmodule

// File: tb/tb_text_screen.sv
// tb_text_screen: drives bytes into text_screen, tracks a logical-grid screen model,
// and compares raster lookups against expectations queued as each pixel is driven.
module tb_text_screen;
    logic       clk_pixel = 1'b0;
    logic       ext_reset = 1'b0;
    logic [9:0] cx = 10'd0, cy = 10'd0;
    logic       char_valid = 1'b0;
    logic [7:0] char_data = 8'd0, char_attr = 8'd0;
    logic       char_ready;
    logic [7:0] codepoint, attribute;
    logic [6:0] cursor_col;
    logic [4:0] cursor_row;

    localparam logic [15:0] BLANK = 16'h0F20;

    int errors = 0;
    int checks = 0;
    logic [15:0] scr [0:29][0:79];
    int mcol, mrow;
    logic [15:0] sb [$];

    text_screen dut (
        .clk_pixel (clk_pixel),
        .ext_reset (ext_reset),
        .cx        (cx),
        .cy        (cy),
        .char_valid(char_valid),
        .char_data (char_data),
        .char_attr (char_attr),
        .char_ready(char_ready),
        .codepoint (codepoint),
        .attribute (attribute),
        .cursor_col(cursor_col),
        .cursor_row(cursor_row)
    );

    always #5 clk_pixel = ~clk_pixel;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_pixel);
        #1;
    endtask

    task automatic blank_all();
        for (int r = 0; r < 30; r++)
            for (int c = 0; c < 80; c++)
                scr[r][c] = BLANK;
        mcol = 0;
        mrow = 0;
    endtask

    task automatic model(input logic [7:0] b, input logic [7:0] a);
        logic lf;
        lf = 1'b0;
        if (b == 8'h0A) begin
            mcol = 0;
            lf = 1'b1;
        end else if (b == 8'h0D)
            mcol = 0;
        else if (b == 8'h08) begin
            if (mcol > 0) begin
                mcol--;
                scr[mrow][mcol] = BLANK;
            end
        end else if (b == 8'h0C)
            blank_all();
        else begin
            scr[mrow][mcol] = {a, b};
            if (mcol == 79) begin
                mcol = 0;
                lf = 1'b1;
            end else
                mcol++;
        end
        if (lf && mrow < 29)
            mrow++;
        else if (lf) begin
            for (int r = 0; r < 29; r++)
                for (int c = 0; c < 80; c++)
                    scr[r][c] = scr[r+1][c];
            for (int c = 0; c < 80; c++)
                scr[29][c] = BLANK;
        end
    endtask

    task automatic send(input logic [7:0] b, input logic [7:0] a, output int waited);
        char_valid = 1'b1;
        char_data  = b;
        char_attr  = a;
        waited = 0;
        while (!char_ready && waited < 5000) begin
            tick();
            waited++;
        end
        if (!char_ready)
            check("send_timeout", {31'd0, char_ready}, 32'd1);
        tick();
        char_valid = 1'b0;
        model(b, a);
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!char_ready && n < 5000) begin
            tick();
            n++;
        end
    endtask

    function automatic logic [15:0] expv(input int x, input int y);
        return (x < 640 && y < 480) ? scr[y/16][x/8] : 16'h0000;
    endfunction

    task automatic scan(input int x0, input int y0, input int n, input string tag);
        int x, y;
        x = (x0 == 0) ? 799 : x0 - 1;
        y = (x0 == 0) ? ((y0 == 0) ? 524 : y0 - 1) : y0;
        cx = 10'(x);
        cy = 10'(y);
        for (int i = 0; i < n; i++) begin
            if (x == 799) begin
                x = 0;
                y = (y == 524) ? 0 : y + 1;
            end else
                x++;
            sb.push_back(expv(x, y));
            tick();
            cx = 10'(x);
            cy = 10'(y);
            check(tag, {16'd0, attribute, codepoint}, {16'd0, sb.pop_front()});
        end
    endtask

    task automatic check_cursor(input string tag);
        check(tag, {20'd0, cursor_row, cursor_col}, 32'(mrow * 128 + mcol));
    endtask

    initial begin
        int w, tot, n;
        cx = 10'd16;
        cy = 10'd16;
        repeat (3) tick();
        check("rst_pix", {16'd0, attribute, codepoint}, 32'd0);
        check("rst_rdy", {31'd0, char_ready}, 32'd0);
        check("rst_cur", {20'd0, cursor_row, cursor_col}, 32'd0);
        ext_reset = 1'b1;
        wait_ready(n);
        check("boot_cycles", n, 32'd2400);
        blank_all();
        scan(0, 0, 800, "frame_line0");
        scan(0, 479, 1602, "frame_vblank");
        scan(700, 524, 200, "frame_wrap");

        send(8'h41, 8'h1E, w);
        check_cursor("a_cursor");
        scan(0, 0, 10, "a_top");
        scan(0, 15, 10, "a_bottom");
        scan(790, 15, 20, "a_next_row");

        send(8'h0D, 8'h00, w);
        tot = 0;
        for (int i = 0; i < 81; i++) begin
            send(8'(8'h30 + i % 10), 8'h07, w);
            tot += w;
        end
        check("wrap_ready", tot, 32'd0);
        check_cursor("wrap_cursor");
        scan(600, 0, 60, "wrap_row0");
        scan(0, 16, 20, "wrap_row1");

        send(8'h0D, 8'h00, w);
        send(8'h08, 8'h00, w);
        check_cursor("bs_col0_cursor");
        scan(0, 16, 8, "bs_col0_cell");
        send(8'h41, 8'h2A, w);
        send(8'h42, 8'h2B, w);
        send(8'h08, 8'h00, w);
        check_cursor("bs_cursor");
        scan(0, 16, 24, "bs_cells");
        send(8'h0D, 8'h00, w);
        check_cursor("cr_cursor");

        send(8'h0C, 8'h00, w);
        wait_ready(n);
        check("clear_cycles", n, 32'd2400);
        check_cursor("clear_cursor");
        scan(0, 0, 16, "clear_r0");
        scan(0, 16, 16, "clear_r1");

        for (int r = 0; r < 30; r++) begin
            for (int c = 0; c < 5; c++)
                send(8'(8'h52 + r), 8'(8'h20 + r), w);
            if (r < 29)
                send(8'h0A, 8'h00, w);
        end
        check_cursor("fill_cursor");
        send(8'h0A, 8'h00, w);
        wait_ready(n);
        check("scroll_cycles", n, 32'd80);
        check_cursor("scroll_cursor");
        for (int r = 0; r < 30; r++)
            scan(0, r * 16 + 8, 48, "scroll_rows");

        send(8'h0A, 8'h00, w);
        repeat (10) tick();
        check("midscroll_busy", {31'd0, char_ready}, 32'd0);
        ext_reset = 1'b0;
        cx = 10'd16;
        cy = 10'd16;
        repeat (3) tick();
        check("rst2_pix", {16'd0, attribute, codepoint}, 32'd0);
        check("rst2_rdy", {31'd0, char_ready}, 32'd0);
        check("rst2_cur", {20'd0, cursor_row, cursor_col}, 32'd0);
        ext_reset = 1'b1;
        wait_ready(n);
        check("reboot_cycles", n, 32'd2400);
        blank_all();
        check_cursor("reboot_cursor");
        send(8'h5A, 8'h4E, w);
        scan(0, 0, 16, "post_rst_r0");
        scan(0, 464, 16, "post_rst_r29");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/text_screen.md
# text_screen

Character-cell text buffer and terminal engine feeding the `console` glyph renderer in the HDMI demo. It accepts a byte stream of characters and control codes through a valid/ready port and stores them with per-character attributes in an 80×30 cell RAM. The RAM is a circular row buffer, so scrolling is cheap. For each pixel it returns the `codepoint` and `attribute` of the cell under (`cx`, `cy`), aligned to the current pixel. This replaces the ad-hoc row counter in the top level.

## Interface
- `COLS`, 80, text columns (8-px cells)
- `ROWS`, 30, text rows (16-px cells)
- `H_TOTAL`, 800, pixels per line including blanking
- `V_TOTAL`, 525, lines per frame including blanking
- `ATTR_DEFAULT`, 8'h0F, attribute written by clear operations

- `clk_pixel`  in  1  pixel clock; all logic in this domain
- `ext_reset`  in  1  asynchronous, active-low reset
- `cx`  in  10  current pixel x from `hdmi`; increments by 1 per clock, wraps `H_TOTAL-1`→0
- `cy`  in  10  current line from `hdmi`; wraps `V_TOTAL-1`→0
- `char_valid`  in  1  write request
- `char_data`  in  8  character or control code
- `char_attr`  in  8  attribute stored with a printable character
- `char_ready`  out  1  engine can accept a byte
- `codepoint`  out  8  cell character for the current pixel, to `console`
- `attribute`  out  8  cell attribute for the current pixel, to `console`
- `cursor_col`  out  7  cursor column, 0..COLS-1
- `cursor_row`  out  5  cursor logical row, 0..ROWS-1

## Operation
- **Storage**
  - Dual-port RAM of COLS×ROWS words, each word {attr[7:0], char[7:0]}.
  - Address = phys_row*COLS + col, where phys_row = (logical_row + top_row) mod ROWS.
  - `top_row` is a 5-bit register.
- **Read path**
  - Lookahead pixel: (`cx`+1, `cy`).
  - When `cx` == H_TOTAL-1, the lookahead is column 0 of line `cy`+1. When `cy` == V_TOTAL-1 in that case, it is line 0.
  - Lookahead cell: col = x>>3, row = y>>4.
  - If the lookahead pixel is outside 640×480 (x ≥ COLS*8 or y ≥ ROWS*16), the next-cycle `codepoint` and `attribute` are forced to 0.
- **FSM states:** CLEAR_ALL, IDLE, CLEAR_ROW.
  - **CLEAR_ALL**
    - Writes {ATTR_DEFAULT, 8'h20} to all COLS*ROWS cells, one per clock, in ascending address order.
    - Sets `top_row`=0 and cursor=(0,0).
    - Then goes to IDLE.
  - **IDLE**
    - `char_ready`=1.
    - On `char_valid`&&`char_ready`, the byte is consumed that cycle and processed as follows:
      - 0x20..0xFF, or any byte not listed below: write {`char_attr`, `char_data`} at the cursor, then col+1. At col COLS-1, set col=0 and do a line feed.
      - 0x0A: col=0, then line feed.
      - 0x0D: col=0.
      - 0x08: if col>0, col-1 and write {ATTR_DEFAULT, 0x20} at the new col. At col 0, no change.
      - 0x0C: enter CLEAR_ALL.
      - Other bytes below 0x20: treated as printable (stored verbatim).
    - Line feed: if row<ROWS-1, row+1. Otherwise scroll: `top_row` ← (top_row+1) mod ROWS, row stays ROWS-1, enter CLEAR_ROW.
  - **CLEAR_ROW**
    - Writes {ATTR_DEFAULT, 0x20} across the new bottom physical row (the old `top_row`), cols 0..COLS-1.
    - Takes COLS clocks, then returns to IDLE.
  - `char_ready`=0 in CLEAR_ALL and CLEAR_ROW.
- **Reset**
  - Asserting `ext_reset` low resets: `codepoint`=0, `attribute`=0, `cursor_col`=0, `cursor_row`=0, `top_row`=0, `char_ready`=0, state=CLEAR_ALL with clear address 0.
  - Reset asserted mid-clear or mid-scroll restarts a full CLEAR_ALL after release.

## Timing
- **Read latency:** 1 clock (synchronous BSRAM read registered on `codepoint`/`attribute`). Because of the lookahead, outputs correspond to the `cx`/`cy` present in the same cycle.
- **Write latency**
  - An accepted byte updates the RAM and cursor on the clock edge that accepts it.
  - The RAM word is visible on the read port for lookups starting the next cycle.
- **Back-to-back:** printable/CR/LF (no scroll)/BS sustain one byte per clock.
- **Blocking durations:**
  - Scroll: `char_ready` low for exactly COLS=80 clocks.
  - Clear: low for COLS*ROWS=2400 clocks.
  - The first `char_ready`=1 after reset release is at cycle 2400.
- **Collision:** a same-address read and write in the same cycle returns the old data (read-first).
- **Arithmetic:**
  - Cursor and `top_row` wrap strictly mod COLS/ROWS; never out of range.
  - Address width is 12 bits; phys_row*80 computed as (r<<6)+(r<<4).
- **Handshake:** `char_data`/`char_attr` are sampled only when `char_valid`&&`char_ready`. `char_valid` may be held indefinitely while `char_ready` is low.

## Test plan
- **Reset:** release `ext_reset` → `char_ready` rises after 2400 clocks. Over a full frame, every visible pixel shows `codepoint`=0x20, `attribute`=0x0F. Blanking shows 0/0.
- **Single char:** write 0x41 with attr 0x1E → pixels cx 0..7, cy 0..15 show 0x41/0x1E. Cursor=(1,0). At cx=799 with cy=15, next cycle (cx=0, cy=16) shows row 1.
- **Line wrap:** write 81 printable bytes 0x30+(i mod 10) → cell (79,0)=0x39 and cell (0,1)=0x30. Cursor=(1,1). `char_ready` stays 1 throughout.
- **Scroll:** fill rows 0..29 with 'R'+row, then send 0x0A at row 29 → `char_ready` low for 80 clocks. Logical row 0 shows row-1 content, row 29 shows 0x20/0x0F, cursor=(0,29).
- **Controls:**
  - 0x08 at col 0 → no change.
  - "AB", 0x08 → cell 1 = 0x20, cursor col 1.
  - 0x0D → col 0.
  - 0x0C → 2400-clock clear, cursor (0,0).
- **Reset mid-scroll:** pulse `ext_reset` low 3 clocks during CLEAR_ROW → outputs 0 during reset, full 2400-clock CLEAR_ALL after release, `top_row`=0.
